// File: rtl/vga_cfg_regbank.sv
// SPI-programmed configuration register bank with shadow/active copies.
// Writes land in shadow registers and are promoted to the active image on
// frame_start, or straight away when the command carries the IMM flag.
// Reads return active values on miso, MSB first, auto-incrementing address.
module vga_cfg_regbank #(
    parameter int unsigned                NUM_REGS    = 4,
    parameter int unsigned                DATA_W      = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUE = 32'hBBFC_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         ss,
    input  logic                         sclk,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    input  logic                         frame_start,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_out,
    output logic                         pending,
    output logic                         commit
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [2:0]                 ss_p;
    logic [2:0]                 sclk_p;
    logic [1:0]                 mosi_p;
    logic                       ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    logic [1:0]                 state;
    logic [CNT_W-1:0]           bit_cnt;
    logic [6:0]                 cmd_sr;
    logic                       is_wr;
    logic                       imm;
    logic [6:0]                 addr;
    logic [6:0]                 addr_nxt;
    logic [DATA_W-2:0]          wsr;
    logic [DATA_W-1:0]          rsr;
    logic [DATA_W-1:0]          word_in;
    logic [DATA_W-1:0]          rd_word;
    logic                       addr_ok;
    logic                       wr_done;
    logic                       word_last;

    logic [NUM_REGS*DATA_W-1:0] shadow;
    logic [NUM_REGS-1:0]        dirty;

    // Two-flop synchronizers plus one previous-sample flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_p   <= '1;
            sclk_p <= '0;
            mosi_p <= '0;
        end else begin
            ss_p   <= {ss_p[1:0], ss};
            sclk_p <= {sclk_p[1:0], sclk};
            mosi_p <= {mosi_p[0], mosi};
        end
    end

    assign ss_fall   =  ss_p[2]   & ~ss_p[1];
    assign ss_rise   = ~ss_p[2]   &  ss_p[1];
    assign sclk_rise =  sclk_p[1] & ~sclk_p[2];
    assign sclk_fall = ~sclk_p[1] &  sclk_p[2];
    assign mosi_s    =  mosi_p[1];

    // Datapath helpers: incoming word, range check, active-register read mux
    always_comb begin
        word_in   = {wsr, mosi_s};
        addr_ok   = 32'(addr) < NUM_REGS;
        addr_nxt  = (addr == '1) ? addr : addr + 1'b1;
        word_last = bit_cnt == CNT_W'(DATA_W - 1);
        wr_done   = ena && !ss_rise && (state == DATA) && is_wr && sclk_rise && word_last;
        rd_word   = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(addr) == i) rd_word = cfg_out[i*DATA_W +: DATA_W];
        end
    end

    // Transaction framing FSM: command decode, write shift-in, read shift-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cmd_sr  <= '0;
            is_wr   <= 1'b0;
            imm     <= 1'b0;
            addr    <= '0;
            wsr     <= '0;
            rsr     <= '0;
        end else if (!ena || ss_rise) begin
            state <= IDLE;
            rsr   <= '0;
        end else if (ss_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
            rsr     <= '0;
        end else begin
            case (state)
                CMD: begin
                    if (sclk_rise) begin
                        cmd_sr <= {cmd_sr[5:0], mosi_s};
                        if (bit_cnt == CNT_W'(7)) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            is_wr   <= cmd_sr[6];
                            imm     <= cmd_sr[5];
                            addr    <= {1'b0, cmd_sr[4:0], mosi_s};
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (is_wr && sclk_rise) begin
                        wsr     <= word_in[DATA_W-2:0];
                        bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
                        if (word_last) addr <= addr_nxt;
                    end else if (!is_wr && sclk_fall) begin
                        // first falling edge of each word loads, the rest shift
                        if (bit_cnt == '0) begin
                            rsr  <= rd_word;
                            addr <= addr_nxt;
                        end else begin
                            rsr <= {rsr[DATA_W-2:0], 1'b0};
                        end
                        bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow/active updates: frame commit first, word write after so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= RESET_VALUE;
            cfg_out <= RESET_VALUE;
            dirty   <= '0;
            commit  <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (ena && frame_start && (|dirty)) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (dirty[i]) cfg_out[i*DATA_W +: DATA_W] <= shadow[i*DATA_W +: DATA_W];
                end
                dirty  <= '0;
                commit <= 1'b1;
            end
            if (wr_done) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (32'(addr) == i) begin
                        shadow[i*DATA_W +: DATA_W] <= word_in;
                        dirty[i]                   <= ~imm;
                        if (imm) cfg_out[i*DATA_W +: DATA_W] <= word_in;
                    end
                end
                if (imm && addr_ok) commit <= 1'b1;
            end
        end
    end

    assign miso    = ena & rsr[DATA_W-1];
    assign miso_oe = ena & ~ss_p[1];
    assign pending = |dirty;

endmodule

// File: tb/tb_vga_cfg_regbank.sv
// Scoreboard bench for vga_cfg_regbank: a register-array model predicts the
// active image at every commit pulse; a monitor process checks each pulse.
module tb_vga_cfg_regbank;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        ss = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        frame_start = 1'b0;
    logic        miso, miso_oe, pending, commit;
    logic [31:0] cfg_out;

    always #5 clk = ~clk;

    vga_cfg_regbank #(
        .NUM_REGS(4),
        .DATA_W(8),
        .RESET_VALUE(32'hBBFC_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .ss(ss),
        .sclk(sclk),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe),
        .frame_start(frame_start),
        .cfg_out(cfg_out),
        .pending(pending),
        .commit(commit)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  act [4];
    logic [7:0]  shd [4];
    bit          dirt [4];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] img();
        return {act[3], act[2], act[1], act[0]};
    endfunction

    function automatic logic any_dirty();
        return dirt[0] | dirt[1] | dirt[2] | dirt[3];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        act  = '{8'h00, 8'h00, 8'hFC, 8'hBB};
        shd  = act;
        dirt = '{0, 0, 0, 0};
        exp_q.delete();
    endtask

    task automatic model_frame();
        if (ena && any_dirty()) begin
            for (int i = 0; i < 4; i++) begin
                if (dirt[i]) act[i] = shd[i];
                dirt[i] = 0;
            end
            exp_q.push_back(img());
        end
    endtask

    task automatic model_word(input logic imm_f, input int a, input logic [7:0] d);
        if (ena && a < 4) begin
            shd[a]  = d;
            dirt[a] = 1;
            if (imm_f) begin
                act[a]  = d;
                dirt[a] = 0;
                exp_q.push_back(img());
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (commit === 1'b1) begin
                if (exp_q.size() == 0) check("commit_unexpected", 32'(commit), 32'd0);
                else check("commit_cfg", cfg_out, exp_q.pop_front());
            end
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        model_frame();
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One SPI mode-0 bit; fs aligns frame_start with this bit's rising-edge strobe
    task automatic spi_bit(input logic b, output logic so, input bit fs);
        mosi = b;
        repeat (HALF) @(negedge clk);
        so   = miso;
        sclk = 1'b1;
        if (fs) begin
            repeat (2) @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        sclk = 1'b0;
    endtask

    task automatic spi_begin();
        ss = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clk);
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic spi_write(input logic [7:0] cmd, input logic [7:0] data [$],
                             input int extra, input bit collide);
        logic so;
        int   a;
        a = int'(cmd[5:0]);
        spi_begin();
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], so, 1'b0);
        foreach (data[n]) begin
            for (int i = 7; i >= 0; i--) begin
                if (i == 0) begin
                    if (collide) model_frame();
                    model_word(cmd[6], a + n, data[n]);
                end
                spi_bit(data[n][i], so, collide && i == 0);
            end
        end
        for (int i = 0; i < extra; i++) spi_bit(1'($urandom), so, 1'b0);
        spi_end();
    endtask

    task automatic spi_read(input int addr, input int nw);
        logic       so;
        logic       cmd_miso;
        logic [7:0] cmd, got, exp;
        cmd      = {2'b00, 6'(addr)};
        cmd_miso = 1'b0;
        spi_begin();
        for (int i = 7; i >= 0; i--) begin
            spi_bit(cmd[i], so, 1'b0);
            cmd_miso = cmd_miso | so;
        end
        check("miso_during_cmd", 32'(cmd_miso), 32'd0);
        for (int n = 0; n < nw; n++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_bit(1'($urandom), so, 1'b0);
                got[i] = so;
            end
            exp = (ena && addr + n < 4) ? act[addr + n] : 8'h00;
            check("read_data", 32'(got), 32'(exp));
        end
        spi_end();
    endtask

    task automatic settle(input string name);
        check({name, "_cfg"}, cfg_out, img());
        check({name, "_pending"}, 32'(pending), 32'(any_dirty()));
        check({name, "_commits_seen"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] data [$];
        logic [7:0] cmd;
        logic       so;
        int         a, nw, extra;

        model_reset();
        fork
            monitor();
        join_none

        // reset values while rst_n is held low
        repeat (3) @(negedge clk);
        check("rst_cfg", cfg_out, 32'hBBFC_0000);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // readback of reg3 then out-of-range reg4
        spi_read(3, 2);

        // deferred write to reg1
        data.delete(); data.push_back(8'h3C);
        spi_write(8'h81, data, 0, 1'b0);
        check("deferred_pending", 32'(pending), 32'd1);
        check("deferred_cfg_held", cfg_out, 32'hBBFC_0000);
        pulse_frame();
        settle("deferred_commit");

        // immediate burst: reg2, reg3, then an ignored out-of-range word
        data.delete(); data.push_back(8'hAA); data.push_back(8'h55); data.push_back(8'h77);
        spi_write(8'hC2, data, 0, 1'b0);
        settle("imm_burst");
        check("imm_burst_image", cfg_out, 32'h55AA_3C00);

        // abort after 5 data bits, then a clean transaction
        data.delete();
        spi_write(8'h80, data, 5, 1'b0);
        settle("abort");
        spi_read(1, 1);

        // frame_start lands on the completing word: reg1 commits, reg0 waits
        data.delete(); data.push_back(8'h11);
        spi_write(8'h81, data, 0, 1'b0);
        data.delete(); data.push_back(8'hE7);
        spi_write(8'h80, data, 0, 1'b1);
        settle("collision");
        check("collision_pending", 32'(pending), 32'd1);
        pulse_frame();
        settle("collision_next_frame");

        // ena low: SPI ignored, commits suppressed, miso quiet
        data.delete(); data.push_back(8'h42);
        spi_write(8'h83, data, 0, 1'b0);
        ena = 1'b0;
        @(negedge clk);
        check("ena_low_miso_oe", 32'(miso_oe), 32'd0);
        data.delete(); data.push_back(8'h5A);
        spi_write(8'hC0, data, 0, 1'b0);
        pulse_frame();
        spi_read(2, 1);
        settle("ena_low");
        ena = 1'b1;
        repeat (2) @(negedge clk);
        pulse_frame();
        settle("ena_restored");

        // randomized transactions and frame pulses
        for (int t = 0; t < 40; t++) begin
            a  = $urandom_range(0, 5);
            nw = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                data.delete();
                for (int n = 0; n < nw; n++) data.push_back(8'($urandom));
                cmd   = {1'b1, 1'($urandom), 6'(a)};
                extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
                spi_write(cmd, data, extra, 1'b0);
            end else begin
                spi_read(a, nw);
            end
            if ($urandom_range(0, 2) == 0) pulse_frame();
            settle("rand");
        end

        // asynchronous reset in the middle of a write
        data.delete(); data.push_back(8'h99);
        spi_write(8'h82, data, 0, 1'b0);
        spi_begin();
        cmd = 8'hC0;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], so, 1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, so, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_cfg", cfg_out, 32'hBBFC_0000);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_miso", 32'(miso), 32'd0);
        ss   = 1'b1;
        sclk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_read(2, 2);
        settle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
